// File: rtl/branch_predict_unit.sv
// Branch unit: 2-bit saturating-counter direction predictor read at IF,
// conditional-branch resolution at EX, table training, registered redirect
// on misprediction, and saturating performance counters.
module branch_predict_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned BHT_DEPTH  = 64,
  parameter int unsigned CNT_W      = 32,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic             ex_pred_taken,
  output logic             br_taken,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             br_illegal,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  // Two-bit saturating counter states; the MSB is the predicted direction.
  typedef enum logic [1:0] {
    SN = 2'b00,
    WN = 2'b01,
    WT = 2'b10,
    ST = 2'b11
  } ctr_e;

  // Conditional branch encodings; 010 and 011 are reserved.
  typedef enum logic [2:0] {
    F_BEQ  = 3'b000,
    F_BNE  = 3'b001,
    F_BLT  = 3'b100,
    F_BGE  = 3'b101,
    F_BLTU = 3'b110,
    F_BGEU = 3'b111
  } funct3_e;

  ctr_e             bht [BHT_DEPTH];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  ctr_e             if_entry;
  ctr_e             ex_entry;
  ctr_e             ctr_next;

  logic             ops_eq;
  logic             ops_lt_signed;
  logic             ops_lt_unsigned;
  logic             funct3_legal;
  logic             cond_taken;

  logic             resolve;
  logic             illegal;
  logic             mispredict;
  logic [XLEN-1:0]  taken_target;
  logic [XLEN-1:0]  fall_through;
  logic [XLEN-1:0]  correct_pc;

  logic             br_count_full;
  logic             mispred_count_full;

  // PC bits outside the word-aligned index field do not select an entry.
  logic             unused_if_pc;
  assign unused_if_pc = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  // Prediction is a pure table read; a same-cycle update is not forwarded.
  always_comb begin
    if_entry      = bht[if_idx];
    if_pred_taken = if_entry[1];
  end

  // Operand comparisons shared by all branch types.
  assign ops_eq          = (ex_rs1 == ex_rs2);
  assign ops_lt_signed   = ($signed(ex_rs1) < $signed(ex_rs2));
  assign ops_lt_unsigned = (ex_rs1 < ex_rs2);

  // Decode branch type into legality and actual outcome.
  always_comb begin
    funct3_legal = 1'b1;
    cond_taken   = 1'b0;
    case (ex_funct3)
      F_BEQ:   cond_taken = ops_eq;
      F_BNE:   cond_taken = ~ops_eq;
      F_BLT:   cond_taken = ops_lt_signed;
      F_BGE:   cond_taken = ~ops_lt_signed;
      F_BLTU:  cond_taken = ops_lt_unsigned;
      F_BGEU:  cond_taken = ~ops_lt_unsigned;
      default: funct3_legal = 1'b0;
    endcase
  end

  assign resolve    = ex_valid & ex_is_branch & funct3_legal;
  assign illegal    = ex_valid & ex_is_branch & ~funct3_legal;
  assign mispredict = resolve & (cond_taken != ex_pred_taken);

  // Both candidate PCs wrap modulo 2^XLEN.
  assign taken_target = ex_pc + ex_imm;
  assign fall_through = ex_pc + XLEN'(4);
  assign correct_pc   = cond_taken ? taken_target : fall_through;

  // Saturating counter step for the entry of the resolving branch.
  always_comb begin
    ex_entry = bht[ex_idx];
    ctr_next = ex_entry;
    if (cond_taken) begin
      case (ex_entry)
        SN:      ctr_next = WN;
        WN:      ctr_next = WT;
        WT:      ctr_next = ST;
        default: ctr_next = ST;
      endcase
    end else begin
      case (ex_entry)
        ST:      ctr_next = WT;
        WT:      ctr_next = WN;
        WN:      ctr_next = SN;
        default: ctr_next = SN;
      endcase
    end
  end

  // Table: bulk initialise on reset, train on each resolved branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= ctr_e'(INIT_STATE);
      end
    end else if (resolve) begin
      bht[ex_idx] <= ctr_next;
    end
  end

  // Registered resolution outputs; pulses drop unless re-asserted each cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_taken    <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      br_illegal  <= 1'b0;
    end else begin
      redirect   <= mispredict;
      br_illegal <= illegal;
      if (resolve) begin
        br_taken <= cond_taken;
      end
      if (mispredict) begin
        redirect_pc <= correct_pc;
      end
    end
  end

  assign br_count_full      = &br_count;
  assign mispred_count_full = &mispred_count;

  // Performance counters saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (resolve && !br_count_full) begin
        br_count <= br_count + CNT_W'(1);
      end
      if (mispredict && !mispred_count_full) begin
        mispred_count <= mispred_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: a reference model predicts each
// cycle's registered outputs when EX stimulus is driven; they are compared
// one cycle later. Small table and narrow counters expose aliasing and
// counter saturation.
module tb_branch_predict_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 4;
  localparam int unsigned CMAX  = 15;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic            ex_valid;
  logic            ex_is_branch;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_rs1, ex_rs2, ex_pc, ex_imm;
  logic            ex_pred_taken;
  logic            br_taken, redirect, br_illegal;
  logic [XLEN-1:0] redirect_pc;
  logic [CW-1:0]   br_count, mispred_count;

  branch_predict_unit #(
    .XLEN       (XLEN),
    .BHT_DEPTH  (DEPTH),
    .CNT_W      (CW),
    .INIT_STATE (2'b01)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_pc         (if_pc),
    .if_pred_taken (if_pred_taken),
    .ex_valid      (ex_valid),
    .ex_is_branch  (ex_is_branch),
    .ex_funct3     (ex_funct3),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_pc         (ex_pc),
    .ex_imm        (ex_imm),
    .ex_pred_taken (ex_pred_taken),
    .br_taken      (br_taken),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .br_illegal    (br_illegal),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            redirect;
    logic [XLEN-1:0] rpc;
    logic            taken;
    logic            ill;
    logic [CW-1:0]   bc;
    logic [CW-1:0]   mc;
  } exp_t;

  exp_t            sb[$];
  int              n_vec = 0;
  int              n_err = 0;

  // Reference model state.
  int              mbht [DEPTH];
  logic            m_taken;
  logic [XLEN-1:0] m_rpc;
  int unsigned     m_bc, m_mc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned idx_of(input logic [XLEN-1:0] pc);
    return (pc / 4) % DEPTH;
  endfunction

  function automatic logic ref_outcome(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic slt;
    slt = $signed(a) < $signed(b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return slt;
      3'b101:  return !slt;
      3'b110:  return a < b;
      3'b111:  return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic compare_popped(input string tag);
    exp_t e;
    e = sb.pop_front();
    check_eq({tag, ".redirect"},    redirect,      e.redirect);
    check_eq({tag, ".redirect_pc"}, redirect_pc,   e.rpc);
    check_eq({tag, ".br_taken"},    br_taken,      e.taken);
    check_eq({tag, ".br_illegal"},  br_illegal,    e.ill);
    check_eq({tag, ".br_count"},    br_count,      e.bc);
    check_eq({tag, ".mispred"},     mispred_count, e.mc);
  endtask

  // Drive one EX cycle (inputs set just after a falling edge), check the
  // pre-update prediction for the same PC, then check registered outputs.
  task automatic step(input string tag, input logic v, input logic b, input logic [2:0] f3,
                      input logic [XLEN-1:0] a, input logic [XLEN-1:0] bb,
                      input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm, input logic pr);
    exp_t        e;
    logic        o, legal, r;
    int unsigned ix;
    ex_valid = v; ex_is_branch = b; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = bb;
    ex_pc = pc; ex_imm = imm; ex_pred_taken = pr; if_pc = pc;
    #1;
    ix = idx_of(pc);
    check_eq({tag, ".pred_pre"}, if_pred_taken, logic'(mbht[ix] >= 2));
    o     = ref_outcome(f3, a, bb);
    legal = !(f3 == 3'b010 || f3 == 3'b011);
    r     = v && b && legal;
    e.redirect = r && (o != pr);
    e.ill      = v && b && !legal;
    if (r) begin
      m_taken = o;
      if (m_bc != CMAX) m_bc++;
      if (o != pr) begin
        if (m_mc != CMAX) m_mc++;
        m_rpc = o ? pc + imm : pc + 32'd4;
      end
      if (o) mbht[ix] = (mbht[ix] == 3) ? 3 : mbht[ix] + 1;
      else   mbht[ix] = (mbht[ix] == 0) ? 0 : mbht[ix] - 1;
    end
    e.taken = m_taken; e.rpc = m_rpc; e.bc = CW'(m_bc); e.mc = CW'(m_mc);
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_popped(tag);
    @(negedge clk);
  endtask

  // Reset edge with an optional mispredicting BEQ sitting in EX.
  task automatic reset_step(input string tag, input logic v, input logic [XLEN-1:0] pc);
    exp_t e;
    rst_n = 1'b0;
    ex_valid = v; ex_is_branch = 1'b1; ex_funct3 = 3'b000; ex_rs1 = 32'd9; ex_rs2 = 32'd9;
    ex_pc = pc; ex_imm = 32'h40; ex_pred_taken = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) mbht[i] = 1;
    m_taken = 1'b0; m_rpc = '0; m_bc = 0; m_mc = 0;
    e.redirect = 1'b0; e.rpc = '0; e.taken = 1'b0; e.ill = 1'b0; e.bc = '0; e.mc = '0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_popped(tag);
    @(negedge clk);
    rst_n = 1'b1;
    ex_valid = 1'b0;
  endtask

  task automatic probe(input string tag, input logic [XLEN-1:0] pc);
    if_pc = pc;
    #1;
    check_eq(tag, if_pred_taken, logic'(mbht[idx_of(pc)] >= 2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]      f3;
    logic [XLEN-1:0] a, b, pc;
    rst_n = 1'b0; if_pc = '0; ex_valid = 1'b0; ex_is_branch = 1'b0; ex_funct3 = '0;
    ex_rs1 = '0; ex_rs2 = '0; ex_pc = '0; ex_imm = '0; ex_pred_taken = 1'b0;
    @(negedge clk);

    // Reset state and initial prediction.
    reset_step("reset", 1'b0, 32'h0);
    probe("pred_init", 32'h100);
    check_eq("pred_init_const", if_pred_taken, 1'b0);

    // BEQ taken but predicted not-taken.
    step("beq_mis", 1, 1, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 0);
    check_eq("beq_rpc_const", redirect_pc, 32'h120);
    probe("pred_after_beq", 32'h100);

    // Signed vs unsigned compare of the same operands.
    step("blt", 1, 1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1);
    step("bltu", 1, 1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h204, 32'h40, 1);

    // Drive one index to ST, then walk it down; back-to-back redirects.
    step("up1", 1, 1, 3'b000, 32'd3, 32'd3, 32'h300, 32'h10, 1);
    step("up2", 1, 1, 3'b000, 32'd3, 32'd3, 32'h300, 32'h10, 1);
    step("dn1", 1, 1, 3'b001, 32'd3, 32'd3, 32'h300, 32'h10, 1);
    step("dn2", 1, 1, 3'b001, 32'd3, 32'd3, 32'h304 - 32'h4, 32'h10, 1);
    step("dn3", 1, 1, 3'b001, 32'd3, 32'd3, 32'h300, 32'h10, 0);
    step("dn4", 1, 1, 3'b001, 32'd3, 32'd3, 32'h300, 32'h10, 0);
    probe("pred_sn", 32'h300);

    // Reserved encodings, masked EX, non-branch.
    step("ill010", 1, 1, 3'b010, 32'd1, 32'd1, 32'h300, 32'h10, 1);
    step("ill011", 1, 1, 3'b011, 32'd1, 32'd2, 32'h300, 32'h10, 0);
    step("masked", 0, 1, 3'b000, 32'd5, 32'd5, 32'h300, 32'h10, 0);
    step("nonbr",  1, 0, 3'b000, 32'd5, 32'd5, 32'h300, 32'h10, 0);
    step("bge",  1, 1, 3'b101, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h180, 32'h8, 0);
    step("bgeu", 1, 1, 3'b111, 32'd1, 32'd2, 32'h184, 32'h8, 1);

    // Mispredict coincident with reset is dropped.
    step("pre_rst", 1, 1, 3'b000, 32'd1, 32'd1, 32'h340, 32'h10, 1);
    reset_step("rst_mis", 1'b1, 32'h340);
    probe("pred_rst", 32'h340);

    // Target wraps past the top of the address space.
    step("wrap", 1, 1, 3'b000, 32'd7, 32'd7, 32'hFFFF_FFFC, 32'h8, 0);
    check_eq("wrap_rpc_const", redirect_pc, 32'h4);

    // Random mix over aliasing PCs; enough resolves to saturate counters.
    for (int n = 0; n < 80; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = (n % 3 == 0) ? 32'($urandom) : 32'($urandom_range(0, 3));
      b  = (n % 3 == 0) ? 32'($urandom) : 32'($urandom_range(0, 3));
      pc = 32'($urandom_range(0, 40)) << 2;
      step("rand", logic'($urandom_range(0, 7) != 0), logic'($urandom_range(0, 5) != 0),
           f3, a, b, pc, 32'($urandom_range(0, 255)) << 1, logic'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
